// File: rtl/fpcvt_seq.sv
// fpcvt_seq: sequential 12-bit two's-complement to small floating-point
// converter. One sample at a time: take the magnitude, normalise it by
// left shifts while counting the exponent down from 7, then round the
// 4-bit significand half-up with overflow into the exponent and
// saturation at the largest code. Result value = (-1)^S * F * 2^E.
//
// Handshake: a sample transfers on a rising edge where in_valid=1 and
// in_ready=1; a result transfers on a rising edge where out_valid=1 and
// out_ready=1. in_ready is high only while idle and out_valid only while
// a result is held, so at most one sample is in flight and requests made
// while busy are dropped rather than queued.
module fpcvt_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] D,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAG   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [11:0] d_q;
  logic [11:0] mag_q;
  logic [2:0]  cnt_q;

  logic [11:0] mag_abs;
  logic        round_bit;
  logic [3:0]  f_raw;
  logic [3:0]  f_rnd;
  logic [2:0]  e_rnd;

  // Magnitude of the captured sample; -2048 has no positive twin, so clamp it.
  always_comb begin
    mag_abs = d_q;
    if (d_q == 12'h800) begin
      mag_abs = 12'h7FF;
    end else if (d_q[11]) begin
      mag_abs = 12'h000 - d_q;
    end
  end

  // Round half-up on the first dropped bit; carry-out renormalises or saturates.
  always_comb begin
    f_raw     = mag_q[10:7];
    round_bit = (cnt_q != 3'd0) && mag_q[6];
    f_rnd     = f_raw;
    e_rnd     = cnt_q;
    if (round_bit) begin
      if (f_raw != 4'b1111) begin
        f_rnd = f_raw + 4'd1;
      end else if (cnt_q != 3'd7) begin
        f_rnd = 4'b1000;
        e_rnd = cnt_q + 3'd1;
      end else begin
        f_rnd = 4'b1111;
        e_rnd = 3'd7;
      end
    end
  end

  // Conversion FSM with registered handshake flags and result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= 12'h000;
      mag_q     <= 12'h000;
      cnt_q     <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= 3'd0;
      F         <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_q      <= D;
            S        <= D[11];
            in_ready <= 1'b0;
            state_q  <= MAG;
          end
        end
        MAG: begin
          mag_q   <= mag_abs;
          cnt_q   <= 3'd7;
          state_q <= NORM;
        end
        NORM: begin
          // Stop once the leading one sits at bit 10 or the exponent bottoms out.
          if (mag_q[10] || (cnt_q == 3'd0)) begin
            state_q <= ROUND;
          end else begin
            mag_q <= {mag_q[10:0], 1'b0};
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ROUND: begin
          F         <= f_rnd;
          E         <= e_rnd;
          out_valid <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          // S/E/F stay put after the handshake; only the flags change.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_seq.sv
// tb_fpcvt_seq: randomized and directed stimulus for fpcvt_seq, checked
// every cycle against an arithmetic reference model of the conversion.
module tb_fpcvt_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] D;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;

  always #5 clk = ~clk;

  fpcvt_seq dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .S         (S),
    .E         (E),
    .F         (F)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_count = 0;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];   // {S,E,F} expected for the sample in flight
  int         lat_q[$];   // expected accept-to-valid latency
  int         acc_q[$];   // cycle number at which the sample was accepted
  logic [7:0] got_q[$];   // results in handshake order
  logic       cur_s = 1'b0;
  logic [6:0] last_ef = 7'd0;
  logic       done_exp;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: value-domain conversion. Below 16 the magnitude is exact with
  // E=0; otherwise E = msb-3 and F = round-half-up(mag / 2^E).
  function automatic void ref_model(input logic [11:0] d, output logic [7:0] sef,
                                    output int lat);
    int v, mag, msb, e, f, n;
    v   = d[11] ? (int'(d) - 4096) : int'(d);
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    msb = -1;
    for (int i = 0; i < 12; i++) if (((mag >> i) & 1) == 1) msb = i;
    if (msb <= 3) begin
      e = 0; f = mag; n = 7;
    end else begin
      e = msb - 3;
      n = 10 - msb;
      f = (mag + (1 << (e - 1))) >> e;
      if (f == 16) begin
        if (e < 7) begin f = 8; e = e + 1; end
        else f = 15;
      end
    end
    sef = {d[11], 3'(e), 4'(f)};
    lat = n + 3;
  endfunction

  // Observe accepts and result handshakes on the active edge (pre-edge values).
  always @(posedge clk) begin
    logic [7:0] sef;
    int lat;
    if (rst) begin
      exp_q.delete(); lat_q.delete(); acc_q.delete();
      cur_s   = 1'b0;
      last_ef = 7'd0;
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        got_q.push_back({S, E, F});
        last_ef = exp_q[0][6:0];
        void'(exp_q.pop_front()); void'(lat_q.pop_front()); void'(acc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        ref_model(D, sef, lat);
        exp_q.push_back(sef);
        lat_q.push_back(lat);
        acc_q.push_back(cyc + 1);
        cur_s = D[11];
        acc_count++;
      end
    end
    cyc++;
  end

  // Compare process: every outputs-visible cycle against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sef", {S, E, F}, 0);
    end else if (exp_q.size() > 0) begin
      done_exp = (cyc >= acc_q[0] + lat_q[0]);
      check("busy_out_valid", out_valid, done_exp);
      check("busy_in_ready", in_ready, 0);
      check("busy_s", S, cur_s);
      if (done_exp) check("result_ef", {E, F}, exp_q[0][6:0]);
      else          check("held_ef", {E, F}, last_ef);
    end else begin
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
      check("idle_s", S, cur_s);
      check("idle_ef", {E, F}, last_ef);
    end
  end

  // ---------------- driver tasks ----------------
  // One conversion; hold = cycles out_ready stays low once the result is up.
  // While busy, in_valid/D carry noise that must be ignored.
  task automatic convert(input logic [11:0] d, input int hold);
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) check("wait_in_ready_timeout", 1, 0);
    D = d; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1)); D = 12'($urandom);
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)); D = 12'($urandom);
      t++;
    end
    if (t >= 40) check("wait_out_valid_timeout", 1, 0);
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1)); D = 12'($urandom);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic wait_accepts(input int target);
    int t = 0;
    while (acc_count < target && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("wait_accept_timeout", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] m_sef;
    int m_lat;
    int n_before;
    int t;
    int base;

    rst = 1'b1; D = 12'h000; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Pin the model on hand-computed cases.
    ref_model(12'h7FF, m_sef, m_lat); check("model_7ff", {m_sef, 8'(m_lat)}, {8'h7F, 8'd3});
    ref_model(12'h000, m_sef, m_lat); check("model_000", {m_sef, 8'(m_lat)}, {8'h00, 8'd10});
    ref_model(12'hFFF, m_sef, m_lat); check("model_fff", {m_sef, 8'(m_lat)}, {8'h81, 8'd10});
    ref_model(12'h07D, m_sef, m_lat); check("model_07d", m_sef, 8'h48);
    ref_model(12'h038, m_sef, m_lat); check("model_038", {m_sef, 8'(m_lat)}, {8'h2E, 8'd8});

    // Directed value and rounding cases.
    convert(12'h7FF, 0); check("dut_7ff", got_q[$], 8'h7F);
    convert(12'h000, 1); check("dut_000", got_q[$], 8'h00);
    convert(12'hFFF, 0); check("dut_fff", got_q[$], 8'h81);
    convert(12'h800, 2); check("dut_800", got_q[$], 8'hFF);
    convert(12'h07D, 0); check("dut_07d", got_q[$], 8'h48);
    convert(12'h038, 0); check("dut_038", got_q[$], 8'h2E);

    // Backpressure: result held 5 cycles with noise on in_valid.
    convert(12'h07D, 5);
    check("bp_result", got_q[$], 8'h48);
    check("bp_idle_after", in_ready, 1);

    // Reset abort during NORM.
    n_before = got_q.size();
    @(negedge clk);
    D = 12'h000; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sef", {S, E, F}, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check("abort_no_result", got_q.size(), n_before);
    convert(12'h7FF, 0); check("after_abort_7ff", got_q[$], 8'h7F);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    base = acc_count;
    n_before = got_q.size();
    out_ready = 1'b1; D = 12'h038; in_valid = 1'b1;
    wait_accepts(base + 1);
    D = 12'hFC8;
    wait_accepts(base + 2);
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) check("b2b_drain_timeout", 1, 0);
    out_ready = 1'b0;
    check("b2b_count", got_q.size(), n_before + 2);
    if (got_q.size() >= n_before + 2) begin
      check("b2b_first", got_q[n_before], 8'h2E);
      check("b2b_second", got_q[n_before + 1], 8'hAE);
    end

    // Randomized conversions with random backpressure and idle gaps.
    for (int i = 0; i < 60; i++) begin
      convert(12'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpcvt_seq.md
FPCVT_SEQ -- requirements
Module: fpcvt_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port D, input, 12 bits: two's-complement sample to convert.
REQ-004 SHALL have port in_valid, input, 1 bit: D is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-006 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: S/E/F hold a completed result.
REQ-008 SHALL have port S, output, 1 bit: sign of the result.
REQ-009 SHALL have port E, output, 3 bits: exponent.
REQ-010 SHALL have port F, output, 4 bits: significand; result value = (-1)^S * F * 2^E.

Function
REQ-011 SHALL implement a five-state FSM: IDLE, MAG, NORM, ROUND, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-013 SHALL accept a sample on the edge where in_valid=1 and in_ready=1: capture D into an internal register, set S=D[11], go to MAG; D changes after acceptance SHALL be ignored.
REQ-014 MAG (1 cycle) SHALL form the 12-bit magnitude: D if D[11]=0, otherwise -D; D=0x800 SHALL clamp to 0x7FF. It SHALL load an exponent counter with 7 and go to NORM.
REQ-015 NORM SHALL check one condition per cycle: if magnitude bit10=1 or the counter=0, go to ROUND; otherwise shift the magnitude left by 1 and decrement the counter.
REQ-016 ROUND (1 cycle) SHALL set F=mag[10:7] and E=counter; the round bit is mag[6] when counter!=0, and no rounding applies when counter=0.
REQ-017 Rounding SHALL be applied in ROUND as follows:
- round bit=1 and F!=1111: F=F+1.
- round bit=1, F=1111, E!=7: F=1000 and E=E+1.
- round bit=1, F=1111, E=7: saturate at F=1111, E=7.
REQ-018 ROUND SHALL go to DONE.
REQ-019 Latency from the accept edge to out_valid=1 SHALL be n+3 cycles, where n = min(lz-1, 7) and lz = leading zeros of the 12-bit magnitude. This gives 3 cycles minimum and 10 cycles maximum.
REQ-020 DONE SHALL hold S/E/F/out_valid stable while out_ready=0.
REQ-021 On an edge in DONE with out_ready=1, the FSM SHALL go to IDLE and drop out_valid; S/E/F SHALL retain their values.
REQ-022 in_valid asserted in any state other than IDLE SHALL be ignored and not queued; the earliest accept after a result is the cycle after the handshake.

Reset
REQ-023 While rst=1 the FSM SHALL be in IDLE, immediately and regardless of clk, with out_valid=0, in_ready=1, S=0, E=000, F=0000, and the internal magnitude and counter cleared.
REQ-024 rst asserted mid-conversion (MAG/NORM/ROUND/DONE) SHALL abort the conversion with no result emitted.
REQ-025 After rst deasserts, the first sample SHALL be accepted on the first edge with in_valid=1.

Verification
REQ-026 Value coverage SHALL include these four cases:
- D=0x7FF -> S=0 E=7 F=1111 (saturate), out_valid 3 cycles after accept.
- D=0x000 -> S=0 E=0 F=0000 after 10 cycles.
- D=0xFFF -> S=1 E=0 F=0001 after 10 cycles.
- D=0x800 -> S=1 E=7 F=1111.
REQ-027 Rounding coverage SHALL include these two cases:
- D=0x07D (125) -> S=0 E=4 F=1000 (round overflow).
- D=0x038 (56) -> S=0 E=2 F=1110 (no round-up).
REQ-028 Backpressure: D=0x07D, out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses ignored. Then out_ready=1 for 1 cycle -> IDLE next cycle.
REQ-029 Reset abort: assert rst during NORM for D=0x000 -> out_valid stays 0, outputs return to 0 asynchronously, and a following D=0x7FF converts correctly.
REQ-030 Back-to-back: in_valid held high with D=0x038 then D=0xFC8 -> two results delivered in order: S=0 E=2 F=1110, then S=1 E=2 F=1110.
